hazard_mult_sched: RTL and testbench

- Hazard and scheduling controller for the 5-stage pipelined MIPS core.
- Generates EX-stage and ID-stage forwarding selects.
- Generates stall and flush controls for the fetch/decode and decode/execute pipeline registers.
- Sequences the multi-cycle multiplier (start/busy/done) and stalls decode while HI/LO results are not ready.

---
 rtl/hazard_mult_sched.sv | 87 ++++++++
 tb/tb_hazard_mult_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_mult_sched.sv
// hazard_mult_sched: forwarding, stall/flush and multi-cycle multiplier sequencing for a 5-stage MIPS pipeline
module hazard_mult_sched #(
    parameter int MULT_CYCLES = 4,
    parameter int CNTW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       start_multD,
    input  logic       start_multE,
    input  logic       hiloreadD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic       mult_load,
    output logic       mult_busy,
    output logic       mult_done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [CNTW-1:0] r_cnt;
    logic            w_lwstall;
    logic            w_brstall;
    logic            w_mdstall;
    logic            w_stall;

    // Forwarding selects; memory stage wins over writeback and $0 is never forwarded
    always_comb begin
        forwardAE = (rsE != 5'd0 && regwriteM && writeregM == rsE) ? 2'b10 :
                    (rsE != 5'd0 && regwriteW && writeregW == rsE) ? 2'b01 : 2'b00;
        forwardBE = (rtE != 5'd0 && regwriteM && writeregM == rtE) ? 2'b10 :
                    (rtE != 5'd0 && regwriteW && writeregW == rtE) ? 2'b01 : 2'b00;
        forwardAD = rsD != 5'd0 && regwriteM && writeregM == rsD;
        forwardBD = rtD != 5'd0 && regwriteM && writeregM == rtD;
    end

    // Stall sources; the HI/LO wait releases in the same cycle the result becomes valid
    always_comb begin
        w_lwstall = memtoregE && (rtE == rsD || rtE == rtD);
        w_brstall = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                                (memtoregM && (writeregM == rsD || writeregM == rtD)));
        w_mdstall = (hiloreadD || start_multD) && ((mult_busy && !mult_done) || start_multE);
        w_stall   = w_lwstall || w_brstall || w_mdstall;
        stallF    = w_stall;
        stallD    = w_stall;
        flushE    = w_stall;
    end

    // Multiplier handshake derived from the state; a load is only accepted while idle
    always_comb begin
        mult_load = start_multE && r_state == IDLE && !reset;
        mult_busy = r_state == BUSY;
        mult_done = r_state == BUSY && r_cnt == CNTW'(1);
    end

    // Countdown sequencer; reset aborts an in-flight multiply without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (mult_load) begin
            r_state <= BUSY;
            r_cnt   <= CNTW'(MULT_CYCLES);
        end else if (r_state == BUSY) begin
            r_state <= (r_cnt == CNTW'(1)) ? IDLE : BUSY;
            r_cnt   <= r_cnt - CNTW'(1);
        end
    end
endmodule

// File: tb/tb_hazard_mult_sched.sv
// tb_hazard_mult_sched: directed checks of forwarding, stalls and multiplier sequencing
module tb_hazard_mult_sched;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, start_multD, start_multE, hiloreadD;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, stallF, stallD, flushE;
    logic       mult_load, mult_busy, mult_done;
    int         checks = 0;
    int         errors = 0;

    hazard_mult_sched #(.MULT_CYCLES(4), .CNTW(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .start_multD(start_multD), .start_multE(start_multE), .hiloreadD(hiloreadD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mult_load(mult_load), .mult_busy(mult_busy), .mult_done(mult_done)
    );

    always #5 clk = ~clk;

    task automatic clr();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, start_multD, start_multE, hiloreadD} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        clr();
        reset = 1'b1;
        start_multE = 1'b1;
        #1;
        checks++;
        if (mult_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", mult_load); end
        step();
        checks++;
        if ({mult_busy, mult_done} !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", {mult_busy, mult_done}); end
        start_multE = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_forward();
        clr();
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; #1;
        checks++;
        if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwdAE_M got %b exp 10", forwardAE); end
        regwriteM = 1'b0; writeregM = 5'd0; writeregW = 5'd3; regwriteW = 1'b1; #1;
        checks++;
        if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwdAE_W got %b exp 01", forwardAE); end
        writeregM = 5'd3; regwriteM = 1'b1; #1;
        checks++;
        if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwdAE_MW got %b exp 10", forwardAE); end
        rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0; #1;
        checks++;
        if (forwardAE !== 2'b00) begin errors++; $display("FAIL fwdAE_r0 got %b exp 00", forwardAE); end
        clr();
        rtE = 5'd7; writeregW = 5'd7; regwriteW = 1'b1; writeregM = 5'd7; #1;
        checks++;
        if (forwardBE !== 2'b01) begin errors++; $display("FAIL fwdBE_W got %b exp 01", forwardBE); end
        clr();
        rsD = 5'd9; rtD = 5'd10; writeregM = 5'd10; regwriteM = 1'b1; #1;
        checks++;
        if ({forwardAD, forwardBD} !== 2'b01) begin errors++; $display("FAIL fwdD got %b exp 01", {forwardAD, forwardBD}); end
    endtask

    task automatic test_lwstall();
        clr();
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5; #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b111) begin errors++; $display("FAIL lw_hit got %b exp 111", {stallF, stallD, flushE}); end
        rsD = 5'd6; #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b000) begin errors++; $display("FAIL lw_miss got %b exp 000", {stallF, stallD, flushE}); end
    endtask

    task automatic test_branch();
        clr();
        branchD = 1'b1; rsD = 5'd4; regwriteE = 1'b1; writeregE = 5'd4; #1;
        checks++;
        if ({stallF, stallD, flushE} !== 3'b111) begin errors++; $display("FAIL br_E got %b exp 111", {stallF, stallD, flushE}); end
        regwriteE = 1'b0; writeregE = 5'd0; writeregM = 5'd4; regwriteM = 1'b1; #1;
        checks++;
        if ({stallD, forwardAD} !== 2'b01) begin errors++; $display("FAIL br_M got %b exp 01", {stallD, forwardAD}); end
        memtoregM = 1'b1; #1;
        checks++;
        if (stallD !== 1'b1) begin errors++; $display("FAIL br_load got %b exp 1", stallD); end
    endtask

    task automatic test_mult_hilo();
        clr();
        start_multE = 1'b1; hiloreadD = 1'b1; #1;
        checks++;
        if ({mult_load, mult_busy, stallD} !== 3'b101) begin errors++; $display("FAIL mul_c0 got %b exp 101", {mult_load, mult_busy, stallD}); end
        step();
        start_multE = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if ({mult_load, mult_busy, mult_done, stallD} !== {1'b0, c <= 4, c == 4, c < 4}) begin
                errors++;
                $display("FAIL mul_c%0d got %b exp %b", c, {mult_load, mult_busy, mult_done, stallD}, {1'b0, c <= 4, c == 4, c < 4});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        clr();
        start_multE = 1'b1; start_multD = 1'b1;
        step();
        start_multE = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            start_multE = (c == 2);
            #1;
            checks++;
            if ({mult_load, mult_busy, mult_done, stallD} !== {1'b0, 1'b1, c == 4, c < 4}) begin
                errors++;
                $display("FAIL b2b_c%0d got %b exp %b", c, {mult_load, mult_busy, mult_done, stallD}, {1'b0, 1'b1, c == 4, c < 4});
            end
            step();
        end
        start_multE = 1'b1; start_multD = 1'b0; #1;
        checks++;
        if ({mult_load, mult_busy} !== 2'b10) begin errors++; $display("FAIL b2b_load2 got %b exp 10", {mult_load, mult_busy}); end
        step();
        start_multE = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if ({mult_busy, mult_done} !== {c <= 4, c == 4}) begin
                errors++;
                $display("FAIL b2b2_c%0d got %b exp %b", c, {mult_busy, mult_done}, {c <= 4, c == 4});
            end
            step();
        end
    endtask

    task automatic test_reset_busy();
        clr();
        start_multE = 1'b1;
        step();
        start_multE = 1'b0;
        step();
        reset = 1'b1; #1;
        checks++;
        if ({mult_busy, mult_done} !== 2'b00) begin errors++; $display("FAIL rstbusy_now got %b exp 00", {mult_busy, mult_done}); end
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({mult_busy, mult_done} !== 2'b00) begin errors++; $display("FAIL rstbusy_after%0d got %b exp 00", c, {mult_busy, mult_done}); end
            step();
        end
        start_multE = 1'b1; #1;
        checks++;
        if (mult_load !== 1'b1) begin errors++; $display("FAIL rst_reload got %b exp 1", mult_load); end
        step();
        start_multE = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if ({mult_busy, mult_done} !== {c <= 4, c == 4}) begin
                errors++;
                $display("FAIL rst_full_c%0d got %b exp %b", c, {mult_busy, mult_done}, {c <= 4, c == 4});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_lwstall();
        test_branch();
        test_mult_hilo();
        test_back_to_back();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
